// File: rtl/result_packer_pkg.sv
// Shared types and constants for the result packer.
//   ENTRY_W     : width of one queued result, {x[15:0], z[7:0]}
//   FRAME_BYTES : bytes per serialized frame (3, or 4 with parity)
//   state_e     : serializer FSM states
// Optional feature macro: RESULT_PACKER_PARITY_EN adds a trailing parity byte.
package result_packer_pkg;

    localparam int unsigned ENTRY_W = 24;

`ifdef RESULT_PACKER_PARITY_EN
    localparam int unsigned FRAME_BYTES = 4;

    typedef enum logic [2:0] {
        StIdle,
        StB0,
        StB1,
        StB2,
        StB3
    } state_e;

    localparam state_e LAST_ST = StB3;

    // XOR of the three payload bytes of an entry.
    function automatic logic [7:0] parity_byte(input logic [ENTRY_W-1:0] entry);
        return entry[23:16] ^ entry[15:8] ^ entry[7:0];
    endfunction
`else
    localparam int unsigned FRAME_BYTES = 3;

    typedef enum logic [1:0] {
        StIdle,
        StB0,
        StB1,
        StB2
    } state_e;

    localparam state_e LAST_ST = StB2;
`endif

endpackage

// File: rtl/result_packer_if.sv
// Bus bundle between the arithmetic datapath, the packer and the byte consumer.
//   in_valid/in_ready/x/z      : result input handshake
//   out_valid/out_ready/out_byte/out_last : byte stream output handshake
//   overflow                   : sticky push-while-full flag
//   count                      : FIFO occupancy (excludes the frame in flight)
// Modports: slave = the packer, master = the surrounding logic / testbench.
interface result_packer_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic          in_ready;
    logic [7:0]    z;
    logic [15:0]   x;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_byte;
    logic          out_last;
    logic          overflow;
    logic [CW-1:0] count;

    modport slave (
        input  in_valid, z, x, out_ready,
        output in_ready, out_valid, out_byte, out_last, overflow, count
    );

    modport master (
        output in_valid, z, x, out_ready,
        input  in_ready, out_valid, out_byte, out_last, overflow, count
    );

endinterface

// File: rtl/result_fifo.sv
// Synchronous FIFO with occupancy count.
//   Clk, Rst       : rising-edge clock, asynchronous active-low reset
//   push, wdata    : write request / data (ignored while full, even with a pop)
//   pop, rdata     : read request / head-of-queue data (combinational read)
//   full, empty    : occupancy flags derived from count
//   count          : number of stored entries
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module result_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by count and pointers.
    always_ff @(posedge Clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/result_packer.sv
// Buffers {x, z} result pairs and serializes each as a byte frame:
// x[15:8], x[7:0], z (+ parity x[15:8]^x[7:0]^z when RESULT_PACKER_PARITY_EN is defined).
//   Clk, Rst : rising-edge clock, asynchronous active-low reset
//   bus      : result_packer_if slave modport (input/output handshakes, overflow, count)
// out_valid/out_byte/out_last are registered; in_ready depends only on FIFO occupancy.
module result_packer
    import result_packer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic            Clk,
    input  logic            Rst,
    result_packer_if.slave  bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic               full, empty, pop;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic [CW-1:0]      fifo_count;

    state_e             state_q, state_d;
    logic [ENTRY_W-1:0] frame_q, frame_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_byte_q, out_byte_d;
    logic               out_last_q, out_last_d;
    logic               overflow_q, overflow_d;
    logic               accept;

    result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (bus.in_valid),
        .wdata ({bus.x, bus.z}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign bus.in_ready  = !full;
    assign bus.count     = fifo_count;
    assign bus.out_valid = out_valid_q;
    assign bus.out_byte  = out_byte_q;
    assign bus.out_last  = out_last_q;
    assign bus.overflow  = overflow_q;

    assign accept = out_valid_q && bus.out_ready;

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        pop        = 1'b0;
        overflow_d = overflow_q | (bus.in_valid & full);

        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    frame_d = fifo_rdata;
                    state_d = StB0;
                end
            end
            StB0: if (accept) state_d = StB1;
            StB1: if (accept) state_d = StB2;
`ifdef RESULT_PACKER_PARITY_EN
            StB2: if (accept) state_d = StB3;
`endif
            default: ;
        endcase

        // End of frame: chain straight into the next queued entry if there is one.
        if (accept && (state_q == LAST_ST)) begin
            if (!empty) begin
                pop     = 1'b1;
                frame_d = fifo_rdata;
                state_d = StB0;
            end else begin
                state_d = StIdle;
            end
        end

        // Outputs are computed from next state so they can be registered.
        out_valid_d = (state_d != StIdle);
        out_last_d  = (state_d == LAST_ST);
        unique case (state_d)
            StB0:    out_byte_d = frame_d[23:16];
            StB1:    out_byte_d = frame_d[15:8];
            StB2:    out_byte_d = frame_d[7:0];
`ifdef RESULT_PACKER_PARITY_EN
            StB3:    out_byte_d = parity_byte(frame_d);
`endif
            default: out_byte_d = 8'h00;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= StIdle;
            frame_q     <= '0;
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'h00;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            out_last_q  <= out_last_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_result_packer.sv
// Directed self-checking bench for result_packer (DEPTH = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_result_packer;

`ifdef RESULT_PACKER_PARITY_EN
    localparam int FB = 4;
`else
    localparam int FB = 3;
`endif

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    result_packer_if #(.DEPTH(4)) bus ();

    result_packer #(.DEPTH(4)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] got_b [$];
    logic       got_l [$];
    int         got_c [$];
    logic [7:0] exp_b [$];
    logic       exp_l [$];
    bit         pat   [$];

    logic [15:0] fx [6] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};
    logic [7:0]  fz [6] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] frame_byte(input logic [15:0] x, input logic [7:0] z,
                                              input int i);
        case (i)
            0:       return x[15:8];
            1:       return x[7:0];
            2:       return z;
            default: return x[15:8] ^ x[7:0] ^ z;
        endcase
    endfunction

    task automatic add_frame(input logic [15:0] x, input logic [7:0] z);
        for (int i = 0; i < FB; i++) begin
            exp_b.push_back(frame_byte(x, z, i));
            exp_l.push_back(i == FB - 1);
        end
    endtask

    // Called and returns on a falling edge; one-cycle push.
    task automatic push1(input logic [15:0] x, input logic [7:0] z);
        bus.in_valid = 1'b1;
        bus.x        = x;
        bus.z        = z;
        @(negedge Clk);
        bus.in_valid = 1'b0;
    endtask

    // Drives out_ready (from pat while bytes are offered, else 1) and records accepted
    // bytes; checks that stalled bytes hold steady.
    task automatic collect(input int n, input int max_cycles);
        int         vi = 0;
        bit         prev_stall = 1'b0;
        logic [7:0] pb = 8'h00;
        logic       pl = 1'b0;
        bit         rdy;
        got_b.delete();
        got_l.delete();
        got_c.delete();
        for (int c = 0; c < max_cycles && got_b.size() < n; c++) begin
            if (c > 0) @(negedge Clk);
            if (prev_stall) begin
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_byte", 32'(bus.out_byte), 32'(pb));
                chk("stall_last", 32'(bus.out_last), 32'(pl));
            end
            rdy = 1'b1;
            if (bus.out_valid) begin
                if (vi < pat.size()) rdy = pat[vi];
                vi++;
            end
            bus.out_ready = rdy;
            if (bus.out_valid && rdy) begin
                got_b.push_back(bus.out_byte);
                got_l.push_back(bus.out_last);
                got_c.push_back(c);
            end
            prev_stall = bus.out_valid && !rdy;
            pb         = bus.out_byte;
            pl         = bus.out_last;
        end
        chk("collect_count", 32'(got_b.size()), 32'(n));
        pat.delete();
    endtask

    task automatic compare(input string tag, input bit contiguous);
        for (int i = 0; i < exp_b.size(); i++) begin
            if (i < got_b.size()) begin
                chk({tag, "_byte"}, 32'(got_b[i]), 32'(exp_b[i]));
                chk({tag, "_last"}, 32'(got_l[i]), 32'(exp_l[i]));
                if (contiguous) chk({tag, "_gap"}, 32'(got_c[i]), 32'(got_c[0] + i));
            end
        end
        exp_b.delete();
        exp_l.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.z         = '0;
        bus.out_ready = 1'b0;

        // Reset state
        @(negedge Clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_byte", 32'(bus.out_byte), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        Rst = 1'b1;
        @(negedge Clk);

        // Single frame: first byte one cycle after the push edge
        bus.out_ready = 1'b1;
        push1(16'h1234, 8'h5A);
        chk("single_pre_valid", 32'(bus.out_valid), 32'd0);
        chk("single_count", 32'(bus.count), 32'd1);
        collect(FB, 20);
        if (got_c.size() > 0) chk("single_latency", 32'(got_c[0]), 32'd1);
`ifdef RESULT_PACKER_PARITY_EN
        exp_b = '{8'h12, 8'h34, 8'h5A, 8'h7C};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
        exp_b = '{8'h12, 8'h34, 8'h5A};
        exp_l = '{1'b0, 1'b0, 1'b1};
`endif
        compare("single", 1'b1);
        @(negedge Clk);
        chk("single_idle_valid", 32'(bus.out_valid), 32'd0);

        // Backpressure: ready toggles 1,0,0,1,0,1 while bytes are offered
        push1(16'hABCD, 8'hEF);
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        collect(FB, 40);
        add_frame(16'hABCD, 8'hEF);
        compare("bp", 1'b0);
        @(negedge Clk);
        chk("bp_idle_valid", 32'(bus.out_valid), 32'd0);

        // Full / overflow: six back-to-back pushes with the consumer stalled
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.x        = fx[i];
            bus.z        = fz[i];
            @(negedge Clk);
            if (i == 3) chk("full_in_ready_4th", 32'(bus.in_ready), 32'd1);
            if (i == 4) begin
                chk("full_count_5th", 32'(bus.count), 32'd4);
                chk("full_in_ready_5th", 32'(bus.in_ready), 32'd0);
                chk("full_overflow_5th", 32'(bus.overflow), 32'd0);
            end
            if (i == 5) begin
                chk("full_overflow_6th", 32'(bus.overflow), 32'd1);
                chk("full_count_6th", 32'(bus.count), 32'd4);
            end
        end
        bus.in_valid = 1'b0;
        collect(5 * FB, 100);
        for (int f = 0; f < 5; f++) add_frame(fx[f], fz[f]);
        compare("drain", 1'b1);
        @(negedge Clk);
        chk("drain_idle_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_count", 32'(bus.count), 32'd0);
        chk("overflow_sticky", 32'(bus.overflow), 32'd1);

        // Back-to-back frames with no idle bubble
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.x         = 16'h0001;
        bus.z         = 8'h02;
        @(negedge Clk);
        bus.x         = 16'hFFFF;
        bus.z         = 8'h00;
        @(negedge Clk);
        bus.in_valid  = 1'b0;
        collect(2 * FB, 30);
`ifdef RESULT_PACKER_PARITY_EN
        exp_b = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hFF, 8'hFF, 8'h00, 8'h00};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        exp_b = '{8'h00, 8'h01, 8'h02, 8'hFF, 8'hFF, 8'h00};
        exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`endif
        compare("b2b", 1'b1);
        @(negedge Clk);
        chk("b2b_idle_valid", 32'(bus.out_valid), 32'd0);

        // Reset mid-frame: in B1 with two entries queued
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.x = 16'hC0DE; bus.z = 8'h11; @(negedge Clk);
        bus.x = 16'hBEEF; bus.z = 8'h22; @(negedge Clk);
        bus.x = 16'hF00D; bus.z = 8'h33; @(negedge Clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge Clk);
        bus.out_ready = 1'b0;
        chk("mid_b1_byte", 32'(bus.out_byte), 32'h0000_00DE);
        chk("mid_count", 32'(bus.count), 32'd2);
        #2 Rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_byte", 32'(bus.out_byte), 32'd0);
        chk("mid_rst_last", 32'(bus.out_last), 32'd0);
        chk("mid_rst_overflow", 32'(bus.overflow), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge Clk);
        Rst           = 1'b1;
        bus.out_ready = 1'b1;
        seen          = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("no_stale_bytes", 32'(seen), 32'd0);
        push1(16'h2468, 8'h9C);
        collect(FB, 20);
        add_frame(16'h2468, 8'h9C);
        compare("post_rst", 1'b1);
        @(negedge Clk);
        chk("post_rst_idle", 32'(bus.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
